// File: rtl/bs_player_board.sv
// Per-player Battleship board: ship placement, opponent attack legality and
// hit/miss resolution, plus this player's own cumulative attack vector.
module bs_player_board #(
  parameter int CELLS = 10,
  parameter int CW    = $clog2(CELLS+1)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [CELLS-1:0] ships,
  input  logic             place,
  input  logic             start,
  input  logic [CELLS-1:0] opp_attack,
  input  logic             opp_valid,
  input  logic [CELLS-1:0] own_sel,
  input  logic             fire,
  output logic             alive,
  output logic             ok,
  output logic             hit,
  output logic             miss,
  output logic             fire_ack,
  output logic [CELLS-1:0] my_attack,
  output logic [CW-1:0]    ships_left,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {SETUP = 2'd0, PLAY = 2'd1, RESOLVE = 2'd2, DEAD = 2'd3} state_t;

  function automatic logic [CW-1:0] popcnt(input logic [CELLS-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < CELLS; i++) c = c + CW'(v[i]);
    return c;
  endfunction

  state_t           state_q, state_d;
  logic [CELLS-1:0] ships_alive_q, ships_alive_d;
  logic [CELLS-1:0] prev_opp_q, prev_opp_d;
  logic [CELLS-1:0] new_q, new_d;
  logic [CELLS-1:0] my_attack_q, my_attack_d;
  logic [CW-1:0]    ships_left_q, ships_left_d;
  logic             ok_q, ok_d, hit_q, hit_d, miss_q, miss_d, fire_ack_q, fire_ack_d;

  logic [CELLS-1:0] new_bits;
  logic             legal, fire_ok;

  // An attack vector is cumulative: exactly one new cell, nothing retracted.
  assign new_bits = opp_attack & ~prev_opp_q;
  assign legal    = (popcnt(new_bits) == CW'(1)) && ((prev_opp_q & ~opp_attack) == '0);
  assign fire_ok  = fire && (popcnt(own_sel) == CW'(1)) && ((own_sel & my_attack_q) == '0) &&
                    (state_q == PLAY || state_q == RESOLVE);

  always_comb begin
    state_d       = state_q;
    ships_alive_d = ships_alive_q;
    prev_opp_d    = prev_opp_q;
    new_d         = new_q;
    my_attack_d   = my_attack_q;
    ships_left_d  = ships_left_q;
    ok_d          = ok_q;
    hit_d         = 1'b0;
    miss_d        = 1'b0;
    fire_ack_d    = 1'b0;

    if (fire_ok) begin
      my_attack_d = my_attack_q | own_sel;
      fire_ack_d  = 1'b1;
    end

    case (state_q)
      SETUP: begin
        if (place) begin
          ships_alive_d = ships;
          ships_left_d  = popcnt(ships);
        end else if (start && ships_left_q != '0) begin
          state_d = PLAY;
        end
      end
      PLAY: begin
        if (opp_valid) begin
          ok_d = legal;
          if (legal) begin
            prev_opp_d = opp_attack;
            new_d      = new_bits;
            state_d    = RESOLVE;
          end
        end
      end
      RESOLVE: begin
        if ((new_q & ships_alive_q) != '0) begin
          hit_d         = 1'b1;
          ships_alive_d = ships_alive_q & ~new_q;
          ships_left_d  = ships_left_q - CW'(1);
          state_d       = (ships_left_q == CW'(1)) ? DEAD : PLAY;
        end else begin
          miss_d  = 1'b1;
          state_d = PLAY;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q       <= SETUP;
      ships_alive_q <= '0;
      prev_opp_q    <= '0;
      new_q         <= '0;
      my_attack_q   <= '0;
      ships_left_q  <= '0;
      ok_q          <= 1'b0;
      hit_q         <= 1'b0;
      miss_q        <= 1'b0;
      fire_ack_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      ships_alive_q <= ships_alive_d;
      prev_opp_q    <= prev_opp_d;
      new_q         <= new_d;
      my_attack_q   <= my_attack_d;
      ships_left_q  <= ships_left_d;
      ok_q          <= ok_d;
      hit_q         <= hit_d;
      miss_q        <= miss_d;
      fire_ack_q    <= fire_ack_d;
    end
  end

  assign alive      = |ships_alive_q;
  assign ok         = ok_q;
  assign hit        = hit_q;
  assign miss       = miss_q;
  assign fire_ack   = fire_ack_q;
  assign my_attack  = my_attack_q;
  assign ships_left = ships_left_q;
  assign state      = state_q;

endmodule

// File: tb/tb_bs_player_board.sv
// Scoreboarded bench for bs_player_board: directed game plus random games
// against a set-based board model; pulses are checked by a separate monitor.
module tb_bs_player_board;
  localparam int CELLS = 10;
  localparam int CW    = $clog2(CELLS+1);

  logic             clk = 1'b0, clr = 1'b0;
  logic [CELLS-1:0] ships = '0, opp_attack = '0, own_sel = '0;
  logic             place = 1'b0, start = 1'b0, opp_valid = 1'b0, fire = 1'b0;
  logic             alive, ok, hit, miss, fire_ack;
  logic [CELLS-1:0] my_attack;
  logic [CW-1:0]    ships_left;
  logic [1:0]       state;

  bs_player_board #(.CELLS(CELLS)) dut (
    .clk(clk), .clr(clr), .ships(ships), .place(place), .start(start),
    .opp_attack(opp_attack), .opp_valid(opp_valid), .own_sel(own_sel), .fire(fire),
    .alive(alive), .ok(ok), .hit(hit), .miss(miss), .fire_ack(fire_ack),
    .my_attack(my_attack), .ships_left(ships_left), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic h; logic [CW-1:0] left; } res_t;
  res_t             res_q[$];
  logic [CELLS-1:0] ack_q[$];

  int tests = 0, fails = 0;

  // Model: board as sets of cells; phase 0=setup, 1=playing, 3=sunk.
  logic [CELLS-1:0] m_alive, m_prev, m_mine;
  logic             m_ok;
  int               m_phase;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    res_t e;
    if (hit && miss) begin
      tests++; fails++;
      $display("FAIL hit_miss_both actual=11 expected=mutex t=%0t", $time);
    end
    if (hit || miss) begin
      if (res_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL spurious_resolve actual=hit%0d/miss%0d expected=none t=%0t", hit, miss, $time);
      end else begin
        e = res_q.pop_front();
        chk("resolve_hit", 32'(hit), 32'(e.h));
        chk("resolve_left", 32'(ships_left), 32'(e.left));
      end
    end
    if (fire_ack) begin
      if (ack_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL spurious_fire_ack actual=1 expected=0 t=%0t", $time);
      end else begin
        chk("fire_ack_my_attack", 32'(my_attack), 32'(ack_q.pop_front()));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    clr = 1'b1;
    #2;
    chk("rst_state", 32'(state), 0);
    chk("rst_alive", 32'(alive), 0);
    chk("rst_left", 32'(ships_left), 0);
    chk("rst_my_attack", 32'(my_attack), 0);
    chk("rst_pulses", {28'd0, ok, hit, miss, fire_ack}, 0);
    res_q.delete(); ack_q.delete();
    m_alive = '0; m_prev = '0; m_mine = '0; m_ok = 1'b0; m_phase = 0;
    @(negedge clk);
    clr = 1'b0;
    tick;
  endtask

  task automatic setup(input logic [CELLS-1:0] s, input logic p, input logic st);
    ships = s; place = p; start = st;
    if (m_phase == 0) begin
      if (p) m_alive = s;
      else if (st && m_alive != '0) m_phase = 1;
    end
    tick;
    place = 1'b0; start = 1'b0;
    chk("setup_state", 32'(state), 32'(m_phase));
    chk("setup_left", 32'(ships_left), 32'($countones(m_alive)));
    chk("setup_alive", 32'(alive), 32'(m_alive != '0));
  endtask

  task automatic model_fire(input logic [CELLS-1:0] s);
    if ($countones(s) == 1 && (s & m_mine) == '0) begin
      m_mine |= s;
      ack_q.push_back(m_mine);
    end
  endtask

  // Cycle A: optional opponent attack + fire. Cycle B: optional fire, and an
  // opponent strobe that lands in RESOLVE (must be ignored) when A was legal.
  task automatic iter(input logic ov, input logic [CELLS-1:0] a, input logic fa, input logic [CELLS-1:0] sa,
                      input logic fb, input logic [CELLS-1:0] sb, input logic ovb, input logic [CELLS-1:0] ab);
    logic [CELLS-1:0] newc;
    logic             lg, legal_a;
    legal_a = 1'b0;
    opp_valid = ov; opp_attack = a; fire = fa; own_sel = sa;
    if (m_phase == 1) begin
      if (fa) model_fire(sa);
      if (ov) begin
        newc = a & ~m_prev;
        lg   = ($countones(newc) == 1) && ((m_prev & ~a) == '0);
        m_ok = lg;
        if (lg) begin
          legal_a = 1'b1;
          m_prev  = a;
          if ((newc & m_alive) != '0) begin
            m_alive &= ~newc;
            res_q.push_back('{1'b1, CW'($countones(m_alive))});
          end else begin
            res_q.push_back('{1'b0, CW'($countones(m_alive))});
          end
        end
      end
    end
    tick;
    opp_valid = ovb && legal_a; opp_attack = ab; fire = fb; own_sel = sb;
    if (m_phase == 1 && fb) model_fire(sb);
    if (legal_a && m_alive == '0) m_phase = 3;
    tick;
    opp_valid = 1'b0; fire = 1'b0;
    chk("iter_state", 32'(state), 32'(m_phase));
    chk("iter_ok", 32'(ok), 32'(m_ok));
    chk("iter_left", 32'(ships_left), 32'($countones(m_alive)));
    chk("iter_alive", 32'(alive), 32'(m_alive != '0));
    chk("iter_my_attack", 32'(my_attack), 32'(m_mine));
  endtask

  function automatic logic [CELLS-1:0] rnd_attack();
    logic [CELLS-1:0] v;
    int k, c;
    k = $urandom_range(0, 9);
    v = m_prev;
    if (k <= 5) begin
      if (m_prev != '1) begin
        do c = $urandom_range(0, CELLS-1); while (m_prev[c]);
        v[c] = 1'b1;
      end
    end else if (k == 6) begin
      v[$urandom_range(0, CELLS-1)] = 1'b1;
      v[$urandom_range(0, CELLS-1)] = 1'b1;
    end else if (k == 7) begin
      v[$urandom_range(0, CELLS-1)] = 1'b0;
    end else if (k == 9) begin
      v = CELLS'($urandom);
    end
    return v;
  endfunction

  function automatic logic [CELLS-1:0] rnd_sel();
    logic [CELLS-1:0] v;
    int k;
    k = $urandom_range(0, 3);
    v = '0;
    if (k <= 1) v[$urandom_range(0, CELLS-1)] = 1'b1;
    else if (k == 2) v = CELLS'($urandom);
    else v = m_mine;
    return v;
  endfunction

  initial begin
    logic [CELLS-1:0] s;
    do_reset;
    // Setup boundaries: empty board cannot start; place wins over start.
    setup(10'h000, 1'b1, 1'b0);
    setup(10'h000, 1'b0, 1'b1);
    setup(10'h007, 1'b1, 1'b1);
    setup(10'h000, 1'b0, 1'b1);
    // Opponent hit, miss, then the three illegal shapes.
    iter(1, 10'h001, 0, '0, 0, '0, 0, '0);
    iter(1, 10'h201, 0, '0, 0, '0, 1, 10'h203);
    iter(1, 10'h207, 0, '0, 0, '0, 0, '0);
    iter(1, 10'h200, 0, '0, 0, '0, 0, '0);
    iter(1, 10'h201, 0, '0, 0, '0, 0, '0);
    // Local fire: accept, repeat, multi-bit.
    iter(0, '0, 1, 10'h010, 0, '0, 0, '0);
    iter(0, '0, 1, 10'h010, 0, '0, 0, '0);
    iter(0, '0, 1, 10'h030, 0, '0, 0, '0);
    // Kill with concurrent fires (one landing in RESOLVE), then dead inputs.
    iter(1, 10'h203, 1, 10'h020, 0, '0, 0, '0);
    iter(1, 10'h207, 0, '0, 1, 10'h040, 0, '0);
    iter(1, 10'h20F, 1, 10'h080, 1, 10'h100, 0, '0);

    for (int g = 0; g < 4; g++) begin
      do_reset;
      s = CELLS'($urandom);
      s[$urandom_range(0, CELLS-1)] = 1'b1;
      setup(s, 1'b1, 1'b0);
      setup('0, 1'b0, 1'b1);
      for (int i = 0; i < 40; i++)
        iter($urandom_range(0, 3) != 0, rnd_attack(), $urandom_range(0, 1) == 1, rnd_sel(),
             $urandom_range(0, 2) == 0, rnd_sel(), $urandom_range(0, 3) == 0, CELLS'($urandom));
    end

    // Clear asserted while a hit is resolving: everything drops at once.
    do_reset;
    setup(10'h3FF, 1'b1, 1'b0);
    setup('0, 1'b0, 1'b1);
    opp_valid = 1'b1; opp_attack = 10'h001;
    tick;
    opp_valid = 1'b0;
    chk("pre_clr_resolve_state", 32'(state), 2);
    do_reset;
    tick;
    chk("post_clr_state", 32'(state), 0);

    chk("res_queue_drained", 32'(res_q.size()), 0);
    chk("ack_queue_drained", 32'(ack_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
